// File: rtl/ntt_bf_feeder.sv
// ntt_bf_feeder: stage-by-stage read/write-back scheduler for a single NTT butterfly PE.
// Issues one (u,v) address pair per cycle for every stage, then drains the PE pipeline
// before the next stage so no stage reads a coefficient whose update is still in flight.
module ntt_bf_feeder #(
  parameter int data_width = 12,
  parameter int LOGN       = 8,
  parameter int NUM_STAGES = 7,
  parameter int PE_LAT_FWD = 5,
  parameter int PE_LAT_INV = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [LOGN-1:0]       rd_addr_u,
  output logic [LOGN-1:0]       rd_addr_v,
  input  logic [data_width-1:0] rd_data_u,
  input  logic [data_width-1:0] rd_data_v,
  output logic [data_width-1:0] u,
  output logic [data_width-1:0] v,
  output logic                  sel,
  output logic                  wr_en,
  output logic [LOGN-1:0]       wr_addr_u,
  output logic [LOGN-1:0]       wr_addr_v,
  output logic [2:0]            stage_idx
);

  localparam int BFW      = LOGN - 1;
  localparam int HALF     = 1 << BFW;
  localparam int DL_DEPTH = 1 + ((PE_LAT_INV > PE_LAT_FWD) ? PE_LAT_INV : PE_LAT_FWD);
  localparam logic [BFW-1:0]  BF_LAST    = BFW'(HALF - 1);
  localparam logic [2:0]      STAGE_LAST = 3'(NUM_STAGES - 1);
  localparam logic [LOGN-1:0] ONE        = LOGN'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [BFW-1:0]  bf_q, bf_d;
  logic [2:0]      stage_q, stage_d;
  logic            sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic            rd_vld_q, rd_vld_d;
  logic [LOGN-1:0] rd_addr_u_q, rd_addr_u_d;
  logic [LOGN-1:0] rd_addr_v_q, rd_addr_v_d;

  logic            dl_valid_q  [DL_DEPTH];
  logic            dl_valid_d  [DL_DEPTH];
  logic [LOGN-1:0] dl_addr_u_q [DL_DEPTH];
  logic [LOGN-1:0] dl_addr_u_d [DL_DEPTH];
  logic [LOGN-1:0] dl_addr_v_q [DL_DEPTH];
  logic [LOGN-1:0] dl_addr_v_d [DL_DEPTH];

  logic            dl_empty;
  logic [3:0]      shift_l;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] bf_ext;
  logic [LOGN-1:0] addr_hi;
  logic [LOGN-1:0] addr_lo;

  // Next-state, butterfly addressing and write-back delay line; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    bf_d    = bf_q;
    stage_d = stage_q;
    sel_d   = sel_q;

    dl_empty = 1'b1;
    for (int i = 0; i < DL_DEPTH; i++) begin
      if (dl_valid_q[i] && (i <= (sel_q ? PE_LAT_INV : PE_LAT_FWD))) begin
        dl_empty = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          bf_d    = '0;
          stage_d = '0;
          sel_d   = mode;
        end
      end
      ST_ISSUE: begin
        if (bf_q == BF_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          bf_d = bf_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dl_empty) begin
          if (stage_q == STAGE_LAST) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 1'b1;
            bf_d    = '0;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d  = (state_d == ST_ISSUE);
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_FINISH);
    rd_vld_d = rd_en_q;

    if (sel_d) begin
      shift_l = 4'(stage_d) + 4'd1;
    end else begin
      shift_l = 4'(LOGN - 1) - 4'(stage_d);
    end
    len     = ONE << shift_l;
    bf_ext  = {1'b0, bf_d};
    addr_hi = (bf_ext >> shift_l) << (shift_l + 4'd1);
    addr_lo = bf_ext & (len - ONE);
    if (rd_en_d) begin
      rd_addr_u_d = addr_hi | addr_lo;
      rd_addr_v_d = (addr_hi | addr_lo) + len;
    end else begin
      rd_addr_u_d = '0;
      rd_addr_v_d = '0;
    end

    dl_valid_d[0]  = rd_en_q;
    dl_addr_u_d[0] = rd_addr_u_q;
    dl_addr_v_d[0] = rd_addr_v_q;
    for (int i = 1; i < DL_DEPTH; i++) begin
      dl_valid_d[i]  = dl_valid_q[i-1];
      dl_addr_u_d[i] = dl_addr_u_q[i-1];
      dl_addr_v_d[i] = dl_addr_v_q[i-1];
    end
  end

  // Single state register for the FSM, counters, registered outputs and delay line; reset flushes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bf_q        <= '0;
      stage_q     <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_u_q <= '0;
      rd_addr_v_q <= '0;
      for (int i = 0; i < DL_DEPTH; i++) begin
        dl_valid_q[i]  <= 1'b0;
        dl_addr_u_q[i] <= '0;
        dl_addr_v_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bf_q        <= bf_d;
      stage_q     <= stage_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_u_q <= rd_addr_u_d;
      rd_addr_v_q <= rd_addr_v_d;
      for (int i = 0; i < DL_DEPTH; i++) begin
        dl_valid_q[i]  <= dl_valid_d[i];
        dl_addr_u_q[i] <= dl_addr_u_d[i];
        dl_addr_v_q[i] <= dl_addr_v_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_u = rd_addr_u_q;
  assign rd_addr_v = rd_addr_v_q;
  assign sel       = sel_q;
  assign stage_idx = stage_q;
  assign u         = rd_vld_q ? rd_data_u : '0;
  assign v         = rd_vld_q ? rd_data_v : '0;
  assign wr_en     = sel_q ? dl_valid_q[PE_LAT_INV]  : dl_valid_q[PE_LAT_FWD];
  assign wr_addr_u = sel_q ? dl_addr_u_q[PE_LAT_INV] : dl_addr_u_q[PE_LAT_FWD];
  assign wr_addr_v = sel_q ? dl_addr_v_q[PE_LAT_INV] : dl_addr_v_q[PE_LAT_FWD];

endmodule

// File: tb/tb_ntt_bf_feeder.sv
// tb_ntt_bf_feeder: per-cycle comparison of ntt_bf_feeder against a transform-level model
// that enumerates butterfly pairs with the textbook nested NTT loops.
module tb_ntt_bf_feeder;

  localparam int N      = 256;
  localparam int HALFN  = 128;
  localparam int STAGES = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        busy, done, rd_en, sel, wr_en;
  logic [7:0]  rd_addr_u, rd_addr_v, wr_addr_u, wr_addr_v;
  logic [11:0] rd_data_u, rd_data_v, u, v;
  logic [2:0]  stage_idx;

  ntt_bf_feeder dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v),
    .rd_data_u(rd_data_u), .rd_data_v(rd_data_v),
    .u(u), .v(v), .sel(sel), .wr_en(wr_en),
    .wr_addr_u(wr_addr_u), .wr_addr_v(wr_addr_v), .stage_idx(stage_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  // Expected behaviour keyed by absolute cycle number.
  bit exp_rd[int];
  bit exp_wr[int];
  bit exp_busy[int];
  bit exp_done[int];
  int exp_ru[int];
  int exp_rv[int];
  int exp_wu[int];
  int exp_wv[int];
  int exp_stage[int];
  int exp_sel[int];
  int model_done_cyc = -1;
  int model_first = 0;

  logic [11:0] mem [N];
  int rd_cnt;
  int wr_cnt;
  int wcnt [STAGES][N];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Transform-level model: standard NTT stage loops, one pair per cycle, fixed drain gap.
  function automatic void model_start(input int f, input bit m);
    int lat, per, len, k, c;
    lat = m ? 6 : 5;
    per = HALFN + lat + 2;
    for (int s = 0; s < STAGES; s++) begin
      len = m ? (2 << s) : (HALFN >> s);
      k = 0;
      for (int base = 0; base < N; base += 2 * len) begin
        for (int j = 0; j < len; j++) begin
          c = f + s * per + k;
          exp_rd[c] = 1'b1;
          exp_ru[c] = base + j;
          exp_rv[c] = base + j + len;
          exp_wr[c + 1 + lat] = 1'b1;
          exp_wu[c + 1 + lat] = base + j;
          exp_wv[c + 1 + lat] = base + j + len;
          k++;
        end
      end
    end
    for (int c2 = f; c2 < f + STAGES * per; c2++) begin
      exp_busy[c2]  = 1'b1;
      exp_stage[c2] = (c2 - f) / per;
      exp_sel[c2]   = int'(m);
    end
    exp_done[f + STAGES * per] = 1'b1;
    model_done_cyc = f + STAGES * per;
    model_first = f;
  endfunction

  function automatic void model_purge(input int from);
    for (int k = from; k < from + 3000; k++) begin
      exp_rd.delete(k); exp_wr.delete(k); exp_busy.delete(k); exp_done.delete(k);
      exp_ru.delete(k); exp_rv.delete(k); exp_wu.delete(k); exp_wv.delete(k);
      exp_stage.delete(k); exp_sel.delete(k);
    end
    model_done_cyc = -1;
  endfunction

  task automatic check_output();
    chk("rd_en", int'(rd_en), int'(exp_rd.exists(cyc)));
    if (exp_rd.exists(cyc)) begin
      chk("rd_addr_u", int'(rd_addr_u), exp_ru[cyc]);
      chk("rd_addr_v", int'(rd_addr_v), exp_rv[cyc]);
    end
    chk("wr_en", int'(wr_en), int'(exp_wr.exists(cyc)));
    if (exp_wr.exists(cyc)) begin
      chk("wr_addr_u", int'(wr_addr_u), exp_wu[cyc]);
      chk("wr_addr_v", int'(wr_addr_v), exp_wv[cyc]);
    end
    chk("busy", int'(busy), int'(exp_busy.exists(cyc)));
    chk("done", int'(done), int'(exp_done.exists(cyc)));
    if (exp_busy.exists(cyc)) begin
      chk("stage_idx", int'(stage_idx), exp_stage[cyc]);
      chk("sel", int'(sel), exp_sel[cyc]);
      if (exp_rd.exists(cyc - 1)) begin
        chk("u_data", int'(u), int'(mem[exp_ru[cyc - 1]]));
        chk("v_data", int'(v), int'(mem[exp_rv[cyc - 1]]));
      end
    end
    if (rd_en === 1'b1) rd_cnt++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (stage_idx < 3'd7) begin
        wcnt[stage_idx][wr_addr_u]++;
        wcnt[stage_idx][wr_addr_v]++;
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) if (chk_en) check_output();

  // Synchronous bank with one-cycle read latency.
  logic       bank_pend;
  logic [7:0] bank_au, bank_av;
  initial begin
    rd_data_u = '0;
    rd_data_v = '0;
    forever begin
      @(negedge clk);
      bank_pend = rd_en;
      bank_au = rd_addr_u;
      bank_av = rd_addr_v;
      @(posedge clk);
      #1;
      if (bank_pend === 1'b1) begin
        rd_data_u = mem[bank_au];
        rd_data_v = mem[bank_av];
      end else begin
        rd_data_u = 12'($urandom);
        rd_data_v = 12'($urandom);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit m);
    start = 1'b1;
    mode = m;
    if (rst && cyc > model_done_cyc) model_start(cyc + 1, m);
    step();
    start = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    model_purge(cyc + 1);
    repeat (n) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_stage", int'(stage_idx), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_rd_addr_u", int'(rd_addr_u), 0);
    chk("rst_rd_addr_v", int'(rd_addr_v), 0);
    chk("rst_wr_addr_u", int'(wr_addr_u), 0);
    chk("rst_u", int'(u), 0);
    rst = 1'b1;
  endtask

  task automatic clear_counts();
    rd_cnt = 0;
    wr_cnt = 0;
    for (int s = 0; s < STAGES; s++)
      for (int a = 0; a < N; a++) wcnt[s][a] = 0;
  endtask

  task automatic run_until_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        start = 1'b1;
        mode = 1'($urandom_range(0, 1));
        if (cyc > model_done_cyc) model_start(cyc + 1, mode);
      end
      step();
      start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic check_run(input bit m);
    int bad;
    int lat;
    lat = m ? 6 : 5;
    chk("done_latency", cyc - model_first, STAGES * (HALFN + lat + 2));
    chk("rd_pulses", rd_cnt, STAGES * HALFN);
    chk("wr_pulses", wr_cnt, STAGES * HALFN);
    bad = 0;
    for (int s = 0; s < STAGES; s++)
      for (int a = 0; a < N; a++) if (wcnt[s][a] != 1) bad++;
    chk("write_once", bad, 0);
  endtask

  initial begin
    int f;
    bit m;
    for (int a = 0; a < N; a++) mem[a] = 12'($urandom_range(0, 3328));
    rst = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    apply_reset(3);
    chk_en = 1;
    repeat (3) step();

    // Reset during ISSUE abandons the transform.
    apply_stimulus(1'b0);
    repeat (30) step();
    apply_reset(3);
    repeat (20) step();

    // Full forward transform, with ignored starts sprinkled in.
    clear_counts();
    apply_stimulus(1'b0);
    f = model_first;
    chk("pin_fwd_u0", exp_ru[f], 0);
    chk("pin_fwd_v0", exp_rv[f], 128);
    chk("pin_fwd_u1", exp_ru[f + 1], 1);
    chk("pin_fwd_v2", exp_rv[f + 2], 130);
    chk("pin_fwd_u127", exp_ru[f + 127], 127);
    chk("pin_fwd_v127", exp_rv[f + 127], 255);
    chk("pin_fwd_wr_lag", int'(exp_wr.exists(f + 6)), 1);
    chk("pin_fwd_s6_v0", exp_rv[f + 6 * 135], 2);
    chk("pin_fwd_s6_u2", exp_ru[f + 6 * 135 + 2], 4);
    chk("pin_fwd_s6_u3", exp_ru[f + 6 * 135 + 3], 5);
    chk("pin_fwd_done", int'(exp_done.exists(f + 945)), 1);
    run_until_done(1200);
    check_run(1'b0);

    // Inverse transform started in the cycle right after done.
    step();
    clear_counts();
    apply_stimulus(1'b1);
    f = model_first;
    chk("pin_inv_v0", exp_rv[f], 2);
    chk("pin_inv_v1", exp_rv[f + 1], 3);
    chk("pin_inv_u2", exp_ru[f + 2], 4);
    chk("pin_inv_s6_v0", exp_rv[f + 6 * 136], 128);
    chk("pin_inv_wr_lag", int'(exp_wr.exists(f + 7)), 1);
    run_until_done(1200);
    check_run(1'b1);

    // Random-mode transforms with random idle gaps.
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(1, 5)) step();
      clear_counts();
      m = 1'($urandom_range(0, 1));
      apply_stimulus(m);
      run_until_done(1200);
      check_run(m);
    end

    repeat (5) step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
